// File: rtl/button_events_pkg.sv
// Shared types and widths for the button event classifier.
package button_events_pkg;

    localparam int BE_TIMER_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        LONG_HELD = 3'd2,
        WAIT      = 3'd3,
        PRESS2    = 3'd4
    } be_state_t;

endpackage

// File: rtl/button_events_timer.sv
// Clearable saturating up-counter used to time press and gap durations.
module button_events_timer
    import button_events_pkg::*;
(
    input  logic                  hwclk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  en,
    output logic [BE_TIMER_W-1:0] count
);

    logic [BE_TIMER_W-1:0] r_count;

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/button_events.sv
// Turns the debounced button level into short/long/double press pulses and a held level.
module button_events
    import button_events_pkg::*;
#(
    parameter logic [31:0] LONG_PRESS_CYCLES = 32'd12000000,
    parameter logic [31:0] DOUBLE_GAP_CYCLES = 32'd3600000
) (
    input  logic hwclk,
    input  logic rst_n,
    input  logic but_in,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic held
);

    localparam logic [BE_TIMER_W-1:0] LONG_LAST = LONG_PRESS_CYCLES - 32'd1;
    localparam logic [BE_TIMER_W-1:0] GAP_LAST  = DOUBLE_GAP_CYCLES - 32'd1;

    be_state_t             r_state;
    be_state_t             w_next;
    logic                  r_prev;
    logic                  r_short;
    logic                  r_long;
    logic                  r_double;
    logic                  r_held;
    logic                  w_short;
    logic                  w_long;
    logic                  w_double;
    logic                  w_clear;
    logic                  w_timer_en;
    logic [BE_TIMER_W-1:0] w_count;

    // Any state change restarts timing for the new state.
    assign w_clear    = (w_next != r_state);
    assign w_timer_en = (r_state == PRESS1) || (r_state == WAIT);

    button_events_timer u_timer (
        .hwclk (hwclk),
        .rst_n (rst_n),
        .clear (w_clear),
        .en    (w_timer_en),
        .count (w_count)
    );

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_prev   <= 1'b1;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_prev   <= but_in;
            r_short  <= w_short;
            r_long   <= w_long;
            r_double <= w_double;
            r_held   <= (w_next == LONG_HELD);
        end
    end

    // Release beats the long threshold; a press beats the gap timeout.
    always_comb begin
        w_next   = r_state;
        w_short  = 1'b0;
        w_long   = 1'b0;
        w_double = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_prev && but_in) w_next = PRESS1;
            end
            PRESS1: begin
                if (!but_in) begin
                    w_next = WAIT;
                end else if (w_count == LONG_LAST) begin
                    w_next = LONG_HELD;
                    w_long = 1'b1;
                end
            end
            LONG_HELD: begin
                if (!but_in) w_next = IDLE;
            end
            WAIT: begin
                if (but_in) begin
                    w_next   = PRESS2;
                    w_double = 1'b1;
                end else if (w_count == GAP_LAST) begin
                    w_next  = IDLE;
                    w_short = 1'b1;
                end
            end
            PRESS2: begin
                if (!but_in) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign short_press  = r_short;
    assign long_press   = r_long;
    assign double_press = r_double;
    assign held         = r_held;

endmodule

// File: tb/tb_button_events.sv
// Self-checking bench: segment-level press model against the button_events outputs.
module tb_button_events;

    localparam int LP   = 8;
    localparam int DG   = 4;
    localparam int MAXN = 512;

    logic hwclk = 1'b0;
    logic rst_n = 1'b0;
    logic but_in = 1'b0;
    logic short_press, long_press, double_press, held;

    // Trace bit order: {short, long, double, held}
    logic       lv   [0:MAXN-1];
    logic [3:0] obs  [0:MAXN-1];
    logic [3:0] expv [0:MAXN-1];
    int n;
    int nseq;
    int vectors = 0;
    int miscompares = 0;

    button_events #(
        .LONG_PRESS_CYCLES (32'd8),
        .DOUBLE_GAP_CYCLES (32'd4)
    ) dut (
        .hwclk        (hwclk),
        .rst_n        (rst_n),
        .but_in       (but_in),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .held         (held)
    );

    always #5 hwclk = ~hwclk;

    task automatic apply_reset(input logic b);
        @(negedge hwclk);
        rst_n  = 1'b0;
        but_in = b;
        repeat (2) @(negedge hwclk);
        rst_n = 1'b1;
    endtask

    task automatic seg(input logic v, input int len);
        for (int j = 0; j < len; j++) begin
            if (n < MAXN) begin
                lv[n] = v;
                n++;
            end
        end
    endtask

    // Drives lv[0..n-1], one value per rising edge, recording outputs after each edge.
    task automatic run_stim();
        for (int i = 0; i < n; i++) begin
            but_in = lv[i];
            @(posedge hwclk);
            #1;
            obs[i] = {short_press, long_press, double_press, held};
            @(negedge hwclk);
        end
    endtask

    // Works on whole press/gap segments: find the press, measure its length and the gap after it.
    task automatic run_model();
        int t, k, p, r, g, s;
        logic pv;
        for (int i = 0; i < MAXN; i++) expv[i] = 4'b0000;
        nseq = 0;
        t = 0;
        while (t < n) begin
            pv = (t == 0) ? 1'b1 : lv[t-1];
            if (lv[t] && !pv) begin
                k = t;
                nseq++;
                p = 0;
                while (k + p < n && lv[k+p]) p++;
                if (p >= LP + 1) begin
                    expv[k+LP][2] = 1'b1;
                    for (int j = k + LP; j < k + p; j++) expv[j][0] = 1'b1;
                    t = k + p + 1;
                end else begin
                    r = k + p;
                    g = 0;
                    while (r + g < n && !lv[r+g]) g++;
                    if (g <= DG && r + g < n) begin
                        expv[r+g][1] = 1'b1;
                        s = r + g;
                        while (s < n && lv[s]) s++;
                        t = s + 1;
                    end else begin
                        if (r + DG < n) expv[r+DG][3] = 1'b1;
                        t = r + DG + 1;
                    end
                end
            end else begin
                t++;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset(1'b0);
        #1;
        vectors++;
        if ({short_press, long_press, double_press, held} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_state got %b exp 0000", {short_press, long_press, double_press, held});
        end
    endtask

    task automatic test_short();
        apply_reset(1'b0);
        n = 0; seg(0, 2); seg(1, 3); seg(0, 20);
        run_stim(); run_model();
        vectors++;
        if (obs[9] !== 4'b1000) begin
            miscompares++;
            $display("FAIL short_pos got %b exp 1000", obs[9]);
        end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin
                miscompares++;
                $display("FAIL short_trace cyc %0d got %b exp %b", i, obs[i], expv[i]);
            end
        end
    endtask

    task automatic test_long();
        apply_reset(1'b0);
        n = 0; seg(0, 2); seg(1, 20); seg(0, 15);
        run_stim(); run_model();
        vectors++;
        if (obs[10] !== 4'b0101 || obs[21] !== 4'b0001 || obs[22] !== 4'b0000) begin
            miscompares++;
            $display("FAIL long_pos got %b/%b/%b exp 0101/0001/0000", obs[10], obs[21], obs[22]);
        end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin
                miscompares++;
                $display("FAIL long_trace cyc %0d got %b exp %b", i, obs[i], expv[i]);
            end
        end
    endtask

    task automatic test_double();
        apply_reset(1'b0);
        n = 0; seg(0, 2); seg(1, 2); seg(0, 2); seg(1, 10); seg(0, 10);
        run_stim(); run_model();
        vectors++;
        if (obs[6] !== 4'b0010) begin
            miscompares++;
            $display("FAIL double_pos got %b exp 0010", obs[6]);
        end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin
                miscompares++;
                $display("FAIL double_trace cyc %0d got %b exp %b", i, obs[i], expv[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        // Release sampled on the 8th edge after recognition: short, never long.
        apply_reset(1'b0);
        n = 0; seg(0, 2); seg(1, 8); seg(0, 20);
        run_stim(); run_model();
        vectors++;
        if (obs[14] !== 4'b1000 || obs[10] !== 4'b0000) begin
            miscompares++;
            $display("FAIL bnd_long got %b/%b exp 1000/0000", obs[14], obs[10]);
        end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin
                miscompares++;
                $display("FAIL bnd_long_trace cyc %0d got %b exp %b", i, obs[i], expv[i]);
            end
        end
        // Second press on the 4th gap edge: double wins over short.
        apply_reset(1'b0);
        n = 0; seg(0, 2); seg(1, 3); seg(0, 4); seg(1, 3); seg(0, 15);
        run_stim(); run_model();
        vectors++;
        if (obs[9] !== 4'b0010) begin
            miscompares++;
            $display("FAIL bnd_gap got %b exp 0010", obs[9]);
        end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin
                miscompares++;
                $display("FAIL bnd_gap_trace cyc %0d got %b exp %b", i, obs[i], expv[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] cur;
        // Reset while in WAIT: the pending short press must never appear.
        apply_reset(1'b0);
        but_in = 1'b0; repeat (2) @(negedge hwclk);
        but_in = 1'b1; repeat (2) @(negedge hwclk);
        but_in = 1'b0; repeat (2) @(negedge hwclk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({short_press, long_press, double_press, held} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_wait got %b exp 0000", {short_press, long_press, double_press, held});
        end
        @(negedge hwclk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge hwclk); #1;
            cur = {short_press, long_press, double_press, held};
            vectors++;
            if (cur !== 4'b0000) begin
                miscompares++;
                $display("FAIL rst_wait_after cyc %0d got %b exp 0000", i, cur);
            end
            @(negedge hwclk);
        end
        // Reset while held drops held asynchronously; button still down after reset is ignored.
        apply_reset(1'b0);
        but_in = 1'b0; repeat (2) @(negedge hwclk);
        but_in = 1'b1; repeat (12) @(negedge hwclk);
        vectors++;
        if (held !== 1'b1) begin
            miscompares++;
            $display("FAIL held_before_rst got %b exp 1", held);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({short_press, long_press, double_press, held} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_held got %b exp 0000", {short_press, long_press, double_press, held});
        end
        @(negedge hwclk);
        rst_n = 1'b1;
        n = 0; seg(1, 15); seg(0, 2); seg(1, 3); seg(0, 15);
        run_stim(); run_model();
        vectors++;
        if (obs[24] !== 4'b1000 || obs[8] !== 4'b0000 || obs[14] !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_held_input got %b/%b/%b exp 1000/0000/0000", obs[24], obs[8], obs[14]);
        end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin
                miscompares++;
                $display("FAIL rst_held_trace cyc %0d got %b exp %b", i, obs[i], expv[i]);
            end
        end
    endtask

    task automatic test_random();
        int npulse, per;
        for (int round = 0; round < 6; round++) begin
            apply_reset($urandom_range(0, 1) == 1 ? 1'b1 : 1'b0);
            n = 0;
            seg(0, $urandom_range(1, 3));
            for (int s = 0; s < 16; s++) begin
                seg(1, $urandom_range(1, 14));
                seg(0, $urandom_range(1, 7));
            end
            seg(0, 20);
            run_stim(); run_model();
            npulse = 0;
            for (int i = 0; i < n; i++) begin
                per = obs[i][3] + obs[i][2] + obs[i][1];
                npulse += per;
                vectors++;
                if (obs[i] !== expv[i] || per > 1) begin
                    miscompares++;
                    $display("FAIL rand r%0d cyc %0d got %b exp %b", round, i, obs[i], expv[i]);
                end
            end
            vectors++;
            if (npulse != nseq) begin
                miscompares++;
                $display("FAIL rand_count r%0d got %0d events exp %0d", round, npulse, nseq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_double();
        test_boundaries();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_events.md
# button_events

Classifies the debounced push-button level into single-cycle event pulses: short press, long press and double press, plus a held level. It sits directly downstream of the button debouncer and consumes its clean, active-high "pressed" level. It gives the user-interface logic press semantics, so no downstream block counts button time itself.

## Interface
- `LONG_PRESS_CYCLES`, default 32'd12000000: hold time, in hwclk cycles, that turns a press into a long press (1 s at 12 MHz); must be >= 2.
- `DOUBLE_GAP_CYCLES`, default 32'd3600000: maximum release-to-second-press gap, in hwclk cycles, for a double press (300 ms); must be >= 2.
- `hwclk` input 1: the single clock; all logic is on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `but_in` input 1: debounced button level, 1 = pressed, synchronous to hwclk.
- `short_press` output 1: one-cycle pulse for a single press released before the long-press threshold with no second press.
- `long_press` output 1: one-cycle pulse when a first press reaches `LONG_PRESS_CYCLES`.
- `double_press` output 1: one-cycle pulse on the second press of a double press.
- `held` output 1: level; high while a long press is still held.

## Operation
- Reset values: state IDLE, timer 0, `prev` = 1, all outputs 0. Reset mid-sequence aborts it, and no pulse is emitted for the aborted sequence.
- Because `prev` resets to 1, a button held through reset release is ignored until it is released and pressed again.
- Timer: 32-bit, cleared on every state transition, increments each cycle in PRESS1 and WAIT, and saturates at all-ones.
- Only `but_in` and `prev` are registered at the input; no further synchronization is done.
- IDLE: `prev`=0 and `but_in`=1 (rising edge) -> PRESS1.
- PRESS1:
  - `but_in`=0 -> WAIT.
  - Else if timer == `LONG_PRESS_CYCLES`-1 -> LONG_HELD, and `long_press` pulses.
- LONG_HELD: `held`=1; `but_in`=0 -> IDLE, and `held` drops.
- WAIT:
  - `but_in`=1 -> PRESS2, and `double_press` pulses.
  - Else if timer == `DOUBLE_GAP_CYCLES`-1 -> IDLE, and `short_press` pulses.
- PRESS2: `but_in`=0 -> IDLE. Long holds in PRESS2 produce no event.
- Simultaneous events:
  - Release on the long-threshold cycle: release wins, so the FSM goes to WAIT and no `long_press` fires.
  - Press on the final gap cycle: press wins, so `double_press` fires and no `short_press` fires.
- At most one of the three pulses is high in any cycle.
- Every sequence emits exactly one event.

## Timing
- All outputs are registered; each pulse is high for exactly one cycle, in the cycle after the deciding edge.
- Edge numbering: edge k is the rising edge on which the press is recognized (IDLE -> PRESS1).
- `long_press`: high in the cycle after edge k+`LONG_PRESS_CYCLES`, provided `but_in` stayed 1 through that edge.
- `held`: rises together with `long_press` and falls one cycle after the edge that samples `but_in`=0.
- Release sampled at edge r (PRESS1 -> WAIT):
  - `short_press` is high after edge r+`DOUBLE_GAP_CYCLES` if no press is sampled in edges r+1..r+`DOUBLE_GAP_CYCLES`.
  - A press sampled in that window gives `double_press` one cycle after the sampling edge.
- The next sequence can start on the edge after returning to IDLE, provided a rising edge is seen.

## Structure
- Package `button_events_pkg` holds:
  - the state enum (IDLE, PRESS1, LONG_HELD, WAIT, PRESS2);
  - `BE_TIMER_W` = 32.
- Optional sub-module `button_events_timer`: a clearable, saturating up-counter with a `count` output and a `clear` input driven by state changes.
- The FSM and output registers stay in the top module.

## Test plan
All scenarios use `LONG_PRESS_CYCLES`=8 and `DOUBLE_GAP_CYCLES`=4.
- Short press:
  - Stimulus: press for 3 cycles, then release.
  - Response: `short_press` high for 1 cycle, 4 cycles after the release edge; no other pulse.
- Long press:
  - Stimulus: press for 20 cycles.
  - Response: `long_press` high 8 cycles after press recognition.
  - Response: `held` high from then until 1 cycle after release; no `short_press` afterwards.
- Double press:
  - Stimulus: press 2 cycles, release 2 cycles, press 10 cycles.
  - Response: `double_press` high 1 cycle after the second press is sampled; no `long_press`; no `short_press`.
- Boundaries:
  - Stimulus: release on exactly the 8th edge after press recognition.
  - Response: no `long_press`; `short_press` follows 4 cycles later.
  - Stimulus: second press on exactly the 4th gap edge.
  - Response: `double_press`, no `short_press`.
- Reset handling:
  - Stimulus: assert `rst_n` low during WAIT.
  - Response: all outputs go to 0 asynchronously; no `short_press` is ever emitted.
  - Stimulus: release `rst_n` with `but_in` held at 1.
  - Response: no events until `but_in` goes 0 and then returns to 1.
- Random press/release traffic with scoreboard model: exactly one event per sequence, and never two pulses in the same cycle.
